lbp_result_streamer: RTL and testbench

//  Read-side counterpart of the LBP processor. Waits for the processor's all_ready, then reads every

---
 rtl/lbp_result_streamer.sv | 216 +++++++++++++++++++++
 tb/tb_lbp_result_streamer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_result_streamer.sv
// lbp_result_streamer
// Read-side companion of the LBP processor. On a rising edge of `start`
// (the processor's all_ready) it walks memory_for_processing in raster order,
// one read per cycle while buffer space allows. Each returned pixel is masked
// to its 8-bit LBP code, or forced to zero on the image border. The result is
// sent out on a valid/ready stream with first/last markers.
//
// Read path: a read issued in cycle t returns r_data in cycle t+1. The word is
// then pushed into a 2-entry shift FIFO, and the FIFO head registers drive the
// stream outputs directly.
//
// Issue rule: a read is issued only if words already buffered, plus the word
// arriving this cycle, minus the word leaving this cycle, is below two. This
// keeps outstanding reads at two or fewer, so the FIFO can never overflow. It
// still sustains one word per cycle when m_ready stays high.
//
// DATA_WIDTH must be greater than 8.

module lbp_result_streamer #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 19,
    parameter int IMG_WIDTH  = 300,
    parameter int IMG_HEIGHT = 400
) (
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  start,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW   = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    // FIFO entry layout: {data, first, last}
    localparam int EW   = DATA_WIDTH + 2;

    localparam logic [CW-1:0]         COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]         ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NPIX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    start_q;
    logic                    busy_q;
    logic                    done_q;

    // raster position of the next read
    logic [ADDR_WIDTH-1:0]   rd_cnt_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;

    // tags travelling one stage alongside the read in flight
    logic                    infl_q;
    logic                    tag_border_q;
    logic                    tag_first_q;
    logic                    tag_last_q;

    // 2-entry shift FIFO; entry 0 is the head and drives the stream outputs
    logic                    v0_q;
    logic                    v1_q;
    logic [EW-1:0]           e0_q;
    logic [EW-1:0]           e1_q;

    logic                    pop;
    logic                    issue;
    logic                    start_edge;
    logic                    is_border;
    logic [1:0]              occ;
    logic [DATA_WIDTH-1:0]   push_word;
    logic [EW-1:0]           push_ent;
    logic                    unused_rdata_hi;

    assign pop        = v0_q & m_ready;
    assign start_edge = start & ~start_q;

    // Bits above the LBP code are never forwarded.
    assign unused_rdata_hi = ^r_data[DATA_WIDTH-1:8];

    // Read-issue decision and border classification of the current address.
    always_comb begin
        occ       = {1'b0, v0_q} + {1'b0, v1_q} + {1'b0, infl_q} - {1'b0, pop};
        issue     = (state_q == S_STREAM) && (occ < 2'd2);
        is_border = (col_q == '0) || (col_q == COL_LAST) ||
                    (row_q == '0) || (row_q == ROW_LAST);
        push_word = tag_border_q ? '0 : {{(DATA_WIDTH-8){1'b0}}, r_data[7:0]};
        push_ent  = {push_word, tag_first_q, tag_last_q};
    end

    assign r_en    = issue;
    assign r_addr  = rd_cnt_q;
    assign m_valid = v0_q;
    assign m_data  = e0_q[EW-1:2];
    assign m_first = e0_q[1];
    assign m_last  = e0_q[0];
    assign busy    = busy_q;
    assign done    = done_q;

    // Frame control: start-edge detection, raster counters and status flags.
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_cnt_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            start_q <= start;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        state_q  <= S_STREAM;
                        busy_q   <= 1'b1;
                        rd_cnt_q <= '0;
                        col_q    <= '0;
                        row_q    <= '0;
                    end
                end
                S_STREAM: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + ADDR_WIDTH'(1);
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (rd_cnt_q == ADDR_LAST) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // finish on the same edge that hands off the final word
                    if (!infl_q && (!v0_q || (!v1_q && pop))) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag pipeline: remembers what the read issued last cycle was.
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            infl_q       <= 1'b0;
            tag_border_q <= 1'b0;
            tag_first_q  <= 1'b0;
            tag_last_q   <= 1'b0;
        end else begin
            infl_q       <= issue;
            tag_border_q <= is_border;
            tag_first_q  <= (rd_cnt_q == '0);
            tag_last_q   <= (rd_cnt_q == ADDR_LAST);
        end
    end

    // Shift FIFO: push returning read data, pop on handshake, head held while stalled.
    always_ff @(posedge clk_p or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            e0_q <= '0;
            e1_q <= '0;
        end else if (pop) begin
            if (v1_q) begin
                e0_q <= e1_q;
                if (infl_q) begin
                    e1_q <= push_ent;
                end else begin
                    v1_q <= 1'b0;
                end
            end else if (infl_q) begin
                e0_q <= push_ent;
            end else begin
                v0_q <= 1'b0;
            end
        end else if (infl_q) begin
            if (!v0_q) begin
                e0_q <= push_ent;
                v0_q <= 1'b1;
            end else begin
                e1_q <= push_ent;
                v1_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lbp_result_streamer.sv
// Testbench for lbp_result_streamer on a 4x3 image.
// A 1-cycle-latency memory model feeds the DUT. Expected words come from the
// raster/border rules applied to the bench's own memory contents.
module tb_lbp_result_streamer;

    localparam int DW   = 12;
    localparam int AW   = 19;
    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_first;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:15];

    int total = 0;
    int bad   = 0;

    // transfers seen: {data, first, last} and the sample cycle of each
    logic [13:0] got [$];
    int          xcyc [$];
    int          cyc = 0;
    int          rcount = 0;
    int          outstanding = 0;
    int          maxout = 0;
    bit          stall_prev = 0;
    logic [14:0] prev_vec = '0;

    lbp_result_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH)
    ) dut (
        .clk_p   (clk),
        .rst     (rst),
        .start   (start),
        .r_en    (r_en),
        .r_addr  (r_addr),
        .r_data  (r_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_first (m_first),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // memory with one cycle of read latency
    always @(posedge clk) begin
        if (r_en) r_data <= mem[r_addr[3:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // reference word for raster address a
    function automatic logic [13:0] exp_word(input int a);
        int         r;
        int         c;
        logic       border;
        logic [11:0] d;
        logic [11:0] w;
        r = a / IW;
        c = a % IW;
        border = (r == 0) || (r == IH - 1) || (c == 0) || (c == IW - 1);
        w = mem[a];
        d = border ? 12'h000 : {4'h0, w[7:0]};
        return {d, (a == 0), (a == NPIX - 1)};
    endfunction

    // observe the DUT at the falling edge
    task automatic sample();
        cyc++;
        if (rst) begin
            outstanding = 0;
            stall_prev  = 0;
            return;
        end
        if (r_en) begin
            rcount++;
            outstanding++;
        end
        if (stall_prev) chk("hold", {17'd0, m_valid, m_data, m_first, m_last}, {17'd0, prev_vec});
        if (m_valid && m_ready) begin
            got.push_back({m_data, m_first, m_last});
            xcyc.push_back(cyc);
            outstanding--;
        end
        if (outstanding > maxout) maxout = outstanding;
        stall_prev = m_valid && !m_ready;
        prev_vec   = {m_valid, m_data, m_first, m_last};
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // mode 0: ready=1, 1: ready 1,0,0,1..., 2: random ready, 3: ready=0 for 20 cycles
    task automatic run_frame(input int mode, input string tag);
        int   gbase;
        int   rbase;
        int   c0;
        bit   fin;
        logic [13:0] w;
        gbase  = got.size();
        rbase  = rcount;
        maxout = 0;
        c0     = 0;
        fin    = 0;
        start  = 1'b1;
        for (int k = 0; k < 600 && !fin; k++) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (k >= 20);
            endcase
            if (mode == 3 && k == 20) begin
                chk({tag, "_reads_stalled"}, rcount - rbase, 2);
                chk({tag, "_valid_stalled"}, {31'd0, m_valid}, 1);
                chk({tag, "_head_stalled"}, {18'd0, m_data, m_first, m_last}, {18'd0, exp_word(0)});
            end
            @(negedge clk);
            sample();
            if (k == 0) c0 = cyc;
            if (k == 1) chk({tag, "_busy"}, {31'd0, busy}, 1);
            if (k == 1 || k == 2) chk({tag, "_valid_early"}, {31'd0, m_valid}, 0);
            if (k == 3) chk({tag, "_valid_first"}, {31'd0, m_valid}, 1);
            if (done) fin = 1;
            @(posedge clk);
            #1;
        end
        chk({tag, "_finished"}, {31'd0, fin}, 1);
        chk({tag, "_count"}, got.size() - gbase, NPIX);
        for (int i = 0; i < NPIX; i++) begin
            w = (gbase + i < got.size()) ? got[gbase + i] : 14'h3fff;
            chk($sformatf("%s_w%0d", tag, i), {18'd0, w}, {18'd0, exp_word(i)});
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 0);
        chk({tag, "_reads"}, rcount - rbase, NPIX);
        chk({tag, "_outstanding"}, {31'd0, (maxout <= 2)}, 1);
        if (mode == 0 && got.size() - gbase == NPIX) begin
            chk({tag, "_lat"}, xcyc[gbase] - c0, 3);
            chk({tag, "_burst"}, xcyc[gbase + NPIX - 1] - xcyc[gbase], NPIX - 1);
        end
        $display("frame %s: words=%0d reads=%0d max_outstanding=%0d", tag, got.size() - gbase, rcount - rbase, maxout);
    endtask

    task automatic frame_end();
        start = 1'b0;
        idle_cycles(2);
    endtask

    initial begin
        int   gbase;
        int   rbase;
        logic [13:0] w;
        rst     = 1'b1;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int a = 0; a < 16; a++) mem[a] = 12'(a + 'h10);
        idle_cycles(3);
        chk("reset_out", {23'd0, r_en, m_valid, m_data, m_first, m_last, busy, done}, 0);
        chk("reset_addr", {13'd0, r_addr}, 0);
        rst = 1'b0;
        idle_cycles(2);

        // T1 + T5: start held high after the frame must not restart it
        run_frame(0, "T1");
        rbase = rcount;
        idle_cycles(10);
        chk("T5_done_held", {31'd0, done}, 1);
        chk("T5_no_reads", rcount - rbase, 0);
        chk("T5_busy_low", {31'd0, busy}, 0);
        frame_end();
        chk("T5_done_cleared", {31'd0, done}, 0);
        run_frame(0, "T5b");
        frame_end();

        // T2: periodic backpressure
        run_frame(1, "T2");
        frame_end();

        // T3: upper nibble of memory word is masked
        mem[5] = 12'hFAB;
        gbase = got.size();
        run_frame(0, "T3");
        w = (gbase + 5 < got.size()) ? got[gbase + 5] : 14'h3fff;
        chk("T3_word5", {20'd0, w[13:2]}, 32'h0AB);
        mem[5] = 12'h015;
        frame_end();

        // T6: long initial stall
        run_frame(3, "T6");
        frame_end();

        // T4: reset after 6 transfers, then a clean restart from address 0
        gbase = got.size();
        start = 1'b1;
        m_ready = 1'b1;
        for (int k = 0; k < 100 && (got.size() - gbase) < 6; k++) tick();
        chk("T4_partial", got.size() - gbase, 6);
        rst = 1'b1;
        #1;
        chk("T4_rst_out", {23'd0, r_en, m_valid, m_data, m_first, m_last, busy, done}, 0);
        start = 1'b0;
        idle_cycles(3);
        rst = 1'b0;
        idle_cycles(2);
        chk("T4_idle", {30'd0, busy, done}, 0);
        run_frame(0, "T4b");
        frame_end();

        // random contents with random backpressure
        for (int f = 0; f < 3; f++) begin
            for (int a = 0; a < 16; a++) mem[a] = 12'($urandom_range(0, 4095));
            run_frame(2, $sformatf("RND%0d", f));
            frame_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
